cmp_seq: RTL and testbench

//   Parametrised, multi-cycle magnitude/equality comparator for branch resolution in the EX stage.

---
 rtl/cmp_pkg.sv | 39 +++
 rtl/cmp_chunk.sv | 16 +
 rtl/cmp_seq.sv | 127 ++++++++++++
 tb/tb_cmp_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential branch comparator: ctrl encodings,
// FSM state type and the final result select.
// No logic of its own; imported by cmp_chunk and cmp_seq.
package cmp_pkg;

  // Branch condition encodings on ctrl; 3'b000 and 3'b111 are unused codes
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_NE  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b011;
  localparam logic [2:0] CMP_LTU = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_GEU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // Map the scan outcome onto the requested condition; unused codes give 0
  function automatic logic cmp_result(input logic [2:0] ctrl,
                                      input logic       eq,
                                      input logic       lt_s,
                                      input logic       ltu);
    logic r;
    r = 1'b0;
    case (ctrl)
      CMP_EQ:  r = eq;
      CMP_NE:  r = !eq;
      CMP_LT:  r = lt_s;
      CMP_LTU: r = ltu;
      CMP_GE:  r = !lt_s;
      CMP_GEU: r = !ltu;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// One CHUNK-bit slice compare: inequality and unsigned less-than.
// Purely combinational, zero latency.
// No handshake; the parent selects which slice is presented.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             neq_o,
  output logic             ltu_o
);

  assign neq_o = (a_i != b_i);
  assign ltu_o = (a_i <  b_i);

endmodule

// File: rtl/cmp_seq.sv
// Multi-cycle magnitude/equality comparator, scanning CHUNK bits per cycle MSB-first.
// Latency: result valid NCHUNK+1 cycles after the accept cycle (earlier on a
//   difference when CMP_SEQ_EARLY_EXIT_EN is defined). Holds result under out_ready=0; accepts only when idle.
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8   // must divide WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  cmp_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       ctrl_q;
  logic [IDXW-1:0]  idx_q;
  logic             decided_q, ltu_q;
  logic             sdiff_q, asign_q;
  logic             c_q, out_valid_q, in_ready_q;

  // Operands viewed as chunk arrays so the scan index selects a slice directly
  logic [NCHUNK-1:0][CHUNK-1:0] a_chunks, b_chunks;
  assign a_chunks = a_q;
  assign b_chunks = b_q;

  logic chunk_neq, chunk_ltu;

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i   (a_chunks[idx_q]),
    .b_i   (b_chunks[idx_q]),
    .neq_o (chunk_neq),
    .ltu_o (chunk_ltu)
  );

  logic decided_d, ltu_d, lt_s_d, res_d, scan_exit;

  // Flag update for the current chunk and the result as it would stand if the scan ended now
  always_comb begin
    decided_d = decided_q | chunk_neq;
    ltu_d     = (!decided_q && chunk_neq) ? chunk_ltu : ltu_q;
    // Differing sign bits settle signed order by A's sign alone
    lt_s_d    = sdiff_q ? asign_q : ltu_d;
    res_d     = cmp_result(ctrl_q, !decided_d, lt_s_d, ltu_d);
`ifdef CMP_SEQ_EARLY_EXIT_EN
    // The first differing chunk from the top fully decides the order
    scan_exit = (idx_q == '0) || (!decided_q && chunk_neq);
`else
    scan_exit = (idx_q == '0);
`endif
  end

  // Control FSM with operand/flag registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      idx_q       <= '0;
      decided_q   <= 1'b0;
      ltu_q       <= 1'b0;
      sdiff_q     <= 1'b0;
      asign_q     <= 1'b0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            ctrl_q     <= ctrl;
            idx_q      <= IDX_TOP;
            decided_q  <= 1'b0;
            ltu_q      <= 1'b0;
            sdiff_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            asign_q    <= a[WIDTH-1];
            in_ready_q <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          decided_q <= decided_d;
          ltu_q     <= ltu_d;
          if (scan_exit) begin
            c_q         <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = c_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Self-checking bench for cmp_seq (WIDTH=32, CHUNK=8): spec vectors, corner
// sequences (backpressure, reset mid-scan) and random requests vs a reference model.
module tb_cmp_seq;

  localparam int W  = 32;
  localparam int CH = 8;
  localparam int NC = W / CH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic [2:0]    ctrl;
  logic          out_valid;
  logic          out_ready;
  logic          c;

  int errors = 0;
  int checks = 0;

  cmp_seq #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: condition truth straight from signed/unsigned arithmetic
  function automatic logic model_c(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mc);
    case (mc)
      3'b001:  return ma == mb;
      3'b010:  return ma != mb;
      3'b011:  return $signed(ma) <  $signed(mb);
      3'b100:  return ma <  mb;
      3'b101:  return $signed(ma) >= $signed(mb);
      3'b110:  return ma >= mb;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: cycles from accept to result (out_valid in cycle T+model_lat+1)
  function automatic int model_lat(input logic [31:0] ma, input logic [31:0] mb);
`ifdef CMP_SEQ_EARLY_EXIT_EN
    for (int k = 1; k <= NC; k++) begin
      if (((ma >> (CH * (NC - k))) & 32'hFF) != ((mb >> (CH * (NC - k))) & 32'hFF))
        return k;
    end
`endif
    return NC;
  endfunction

  // One full request/response; all driving and sampling on negedge.
  // hold: cycles of out_ready=0 after out_valid; poke: drive a competing in_valid meanwhile.
  task automatic run_req(input logic [31:0] ra, input logic [31:0] rb, input logic [2:0] rc,
                         input int hold, input bit poke, input string tag,
                         output logic c_out, output int lat);
    int guard;
    a = ra; b = rb; ctrl = rc; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk({tag, " accept timeout"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk({tag, " out_valid timeout"}, 32'(out_valid), 32'd1);
    c_out = c;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        a = 32'h0; b = 32'h0; ctrl = 3'b001; in_valid = 1'b1;
      end
      @(negedge clk);
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold c"}, 32'(c), 32'(c_out));
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " release out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " release in_ready"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [2:0]  vc;
    logic        exp_c;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic r;
    int   lat;
    logic [31:0] ra, rb;
    logic [2:0]  rc;

    vecs = '{
      '{32'h12345678, 32'h12345678, 3'b001, 1'b1},
      '{32'h12345678, 32'h12345678, 3'b010, 1'b0},
      '{32'hFFFFFFFF, 32'h00000001, 3'b011, 1'b1},
      '{32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b0},
      '{32'hFFFFFFFF, 32'h00000001, 3'b101, 1'b0},
      '{32'hFFFFFFFF, 32'h00000001, 3'b110, 1'b1},
      '{32'h01000000, 32'h00FFFFFF, 3'b110, 1'b1},
      '{32'h00000000, 32'h00000000, 3'b000, 1'b0},
      '{32'h00000000, 32'h00000000, 3'b111, 1'b0},
      '{32'h80000000, 32'h7FFFFFFF, 3'b011, 1'b1},
      '{32'h00000012, 32'h00000034, 3'b100, 1'b1},
      '{32'h00000005, 32'h00000005, 3'b101, 1'b1}
    };

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ctrl = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset c", 32'(c), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Spec vectors: value and latency
    foreach (vecs[i]) begin
      run_req(vecs[i].va, vecs[i].vb, vecs[i].vc, 0, 1'b0, $sformatf("vec%0d", i), r, lat);
      chk($sformatf("vec%0d c", i), 32'(r), 32'(vecs[i].exp_c));
      chk($sformatf("vec%0d out_valid cycle T+", i), 32'(lat + 1), 32'(model_lat(vecs[i].va, vecs[i].vb) + 1));
    end

    // Backpressure with a competing request held off until release
    run_req(32'hFFFFFFFF, 32'h00000001, 3'b011, 3, 1'b1, "bp", r, lat);
    chk("bp c", 32'(r), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp no stray result", 32'(out_valid), 32'd0);
    end

    // Reset mid-scan after a prior c=1 result: nothing stale may appear
    a = 32'h12345678; b = 32'h12345679; ctrl = 3'b100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst c", 32'(c), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst no stale result", 32'(out_valid), 32'd0);
    end

    // Random requests against the reference model
    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        default: rb = ra ^ 32'h80000000;
      endcase
      rc = 3'($urandom_range(0, 7));
      run_req(ra, rb, rc, $urandom_range(0, 2), 1'b0, "rand", r, lat);
      chk($sformatf("rand%0d c a=%0h b=%0h ctrl=%0d", n, ra, rb, rc), 32'(r), 32'(model_c(ra, rb, rc)));
      chk($sformatf("rand%0d latency", n), 32'(lat), 32'(model_lat(ra, rb)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
